// File: rtl/usb_status_fifo_pkg.sv
// Shared definitions for the USB status byte FIFO: read-FSM states, marker
// default, drop-counter width and the saturating-increment helper.
package usb_status_fifo_pkg;

  localparam int         DROP_W     = 16;
  localparam logic [7:0] MARKER_DEF = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_WAIT   = 2'd3
  } rd_state_e;

  // One write into storage per cycle: either a producer byte or the marker.
  typedef struct packed {
    logic       en;
    logic [7:0] data;
  } wr_req_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/usb_status_fifo_ram.sv
// Simple dual-port byte RAM with registered read and no reset, shaped so the
// tools map it onto a single block RAM.
module usb_status_fifo_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_status_fifo.sv
// Byte FIFO and pacer between the USB status producer and a UART transmitter;
// counts overflow drops and injects a marker byte after each loss episode.
module usb_status_fifo
  import usb_status_fifo_pkg::*;
#(
  parameter int         DEPTH  = 1024,
  parameter int         AW     = 10,
  parameter logic [7:0] MARKER = MARKER_DEF
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic [7:0]        wr_d,
  input  logic              wr_dv,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [7:0]        tx_byte,
  output logic              tx_dv,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]       level_q, level_d;
  logic              pend_q, pend_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  rd_state_e         st_q, st_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_dv_q, tx_dv_d;

  logic       empty_w, room_w, full_w;
  logic       drop, mk_wr, rd_pop;
  wr_req_t    wreq;
  logic [7:0] ram_q;

  // Full/empty come from the registered level only, so a read in the same
  // cycle never opens room for a write at level==DEPTH.
  assign empty_w = (level_q == '0);
  assign room_w  = (level_q != LVL_FULL);
  assign full_w  = !room_w || pend_q;

  assign drop       = wr_dv && full_w;
  assign mk_wr      = pend_q && room_w;
  assign wreq.en    = (wr_dv && !full_w) || mk_wr;
  assign wreq.data  = mk_wr ? MARKER : wr_d;

  // The RAM captures mem[rp] on the pop edge; ram_q is therefore valid
  // throughout FETCH and LAUNCH and no write can hit that slot meanwhile.
  usb_status_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (8)
  ) u_ram (
    .clk_i   (clk48),
    .we_i    (wreq.en),
    .waddr_i (wp_q),
    .wdata_i (wreq.data),
    .re_i    (rd_pop),
    .raddr_i (rp_q),
    .rdata_o (ram_q)
  );

  always_comb begin
    st_d      = st_q;
    rd_pop    = 1'b0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    unique case (st_q)
      ST_IDLE: begin
        if (!empty_w && !tx_active) begin
          rd_pop = 1'b1;
          st_d   = ST_FETCH;
        end
      end
      ST_FETCH:  st_d = ST_LAUNCH;
      ST_LAUNCH: begin
        tx_byte_d = ram_q;
        tx_dv_d   = 1'b1;
        st_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wp_d       = wreq.en ? wp_q + PTR_ONE : wp_q;
    rp_d       = rd_pop  ? rp_q + PTR_ONE : rp_q;
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    // A drop in the marker cycle starts a fresh episode, so it wins.
    pend_d     = drop ? 1'b1 : (mk_wr ? 1'b0 : pend_q);
    unique case ({wreq.en, rd_pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      pend_q     <= 1'b0;
      drop_cnt_q <= '0;
      st_q       <= ST_IDLE;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      level_q    <= level_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      st_q       <= st_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_dv    = tx_dv_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign level    = level_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_usb_status_fifo.sv
// Randomised and directed bench for usb_status_fifo: a queue-based reference
// model predicts the byte stream, a scoreboard checks every UART launch.
module tb_usb_status_fifo;
  import usb_status_fifo_pkg::*;

  localparam int         DEPTH = 16;
  localparam int         AW    = 4;
  localparam logic [7:0] MK    = 8'h21;

  logic              clk48 = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        wr_d  = '0;
  logic              wr_dv = 1'b0;
  logic              tx_active;
  logic              tx_done = 1'b0;
  logic [7:0]        tx_byte;
  logic              tx_dv, full, empty;
  logic [AW:0]       level;
  logic [DROP_W-1:0] drop_cnt;

  usb_status_fifo #(.DEPTH(DEPTH), .AW(AW), .MARKER(MK)) dut (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .wr_d      (wr_d),
    .wr_dv     (wr_dv),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_byte   (tx_byte),
    .tx_dv     (tx_dv),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  always #10 clk48 = ~clk48;

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // UART model: frame of uart_len cycles per tx_dv, stall holds tx_active high.
  int   uart_len = 12;
  logic stall = 1'b0;
  logic u_busy = 1'b0;
  int   u_cnt = 0;
  assign tx_active = u_busy || stall;

  always @(negedge clk48) begin
    tx_done = 1'b0;
    if (u_busy) begin
      u_cnt--;
      if (u_cnt == 0) begin
        u_busy  = 1'b0;
        tx_done = 1'b1;
      end
    end else if (tx_dv) begin
      u_busy = 1'b1;
      u_cnt  = uart_len;
    end
  end

  // Reference model: FIFO contents as a queue, a pending-marker flag, a
  // saturating drop count and a reader that is either free or owns one byte
  // until the UART reports done.
  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  logic [7:0]        m_q[$];
  exp_t              sb[$];
  logic              m_pend = 1'b0;
  logic [DROP_W-1:0] m_drop = '0;
  logic              m_busy = 1'b0;
  int                cnt_done = 0;

  always @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      sb.delete();
      m_pend = 1'b0;
      m_drop = '0;
      m_busy = 1'b0;
    end else begin
      int   sz;
      logic m_full, do_pop;
      cyc++;
      sz     = m_q.size();
      m_full = (sz == DEPTH) || m_pend;
      do_pop = !m_busy && sz > 0 && !tx_active;
      if (tx_done) cnt_done++;
      if (m_busy && tx_done) m_busy = 1'b0;
      // Popped byte must reach tx_dv two edges after the pop edge.
      if (do_pop) begin
        exp_t e;
        e.b = m_q.pop_front();
        e.c = cyc + 2;
        sb.push_back(e);
        m_busy = 1'b1;
      end
      if (wr_dv && !m_full) m_q.push_back(wr_d);
      else if (wr_dv && m_drop != 16'hFFFF) m_drop++;
      if (m_pend && sz < DEPTH) begin
        m_q.push_back(MK);
        m_pend = 1'b0;
      end
      if (wr_dv && m_full) m_pend = 1'b1;
    end
  end

  // Monitor: state against the model every cycle, launches against the scoreboard.
  logic [7:0] out_log[$];
  int         cnt_dv = 0;
  int         max_lvl = 0;

  always @(negedge clk48) begin
    if (rst_n) begin
      chk("level", 32'(level), 32'(m_q.size()));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("full", 32'(full), 32'((m_q.size() == DEPTH) || m_pend));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("empty_full_excl", 32'(empty && full), 32'(0));
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (tx_dv || (sb.size() > 0 && sb[0].c == cyc)) begin
        if (sb.size() == 0) begin
          chk("tx_dv_unexpected", 32'(tx_dv), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tx_dv", 32'(tx_dv), 32'(1));
          chk("tx_byte", 32'(tx_byte), 32'(e.b));
          chk("tx_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (tx_dv) begin
        out_log.push_back(tx_byte);
        cnt_dv++;
      end
    end
  end

  task automatic put(input logic [7:0] b);
    wr_d  = b;
    wr_dv = 1'b1;
    @(negedge clk48);
    wr_dv = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((m_q.size() != 0 || sb.size() != 0 || m_busy || u_busy) && n < max_cyc) begin
      @(negedge clk48);
      n++;
    end
    chk("drain_timeout", 32'(n < max_cyc), 32'(1));
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int e, n;
    logic ok;

    // 1: reset state, single byte latency
    repeat (3) @(negedge clk48);
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_tx_dv", 32'(tx_dv), 32'(0));
    chk("rst_tx_byte", 32'(tx_byte), 32'(0));
    chk("rst_drop", 32'(drop_cnt), 32'(0));
    rst_n = 1'b1;
    @(negedge clk48);
    put(8'h41);
    e = cyc;
    n = 0;
    while (!tx_dv && n < 20) begin
      @(negedge clk48);
      n++;
    end
    chk("t1_dv_seen", 32'(tx_dv), 32'(1));
    chk("t1_latency", 32'(cyc - e), 32'(3));
    chk("t1_byte", 32'(tx_byte), 32'(8'h41));
    drain(100);
    chk("t1_empty", 32'(empty), 32'(1));

    // 2: burst of five at real baud pacing
    uart_len = 4340;
    stall    = 1'b1;
    max_lvl  = 0;
    cnt_dv   = 0;
    cnt_done = 0;
    out_log.delete();
    for (int i = 1; i <= 5; i++) put(8'(i));
    stall = 1'b0;
    drain(5 * 4400 + 100);
    chk("t2_peak", 32'(max_lvl), 32'(5));
    chk("t2_count", 32'(out_log.size()), 32'(5));
    ok = (out_log.size() == 5);
    for (int i = 0; i < out_log.size(); i++) if (out_log[i] != 8'(i + 1)) ok = 1'b0;
    chk("t2_order", 32'(ok), 32'(1));
    chk("t2_dv_vs_done", 32'(cnt_dv), 32'(cnt_done));

    // 3: overflow with stalled UART, marker after drain
    uart_len = 12;
    stall    = 1'b1;
    for (int i = 0; i < 20; i++) put(8'h30 + 8'(i));
    chk("t3_level", 32'(level), 32'(16));
    chk("t3_full", 32'(full), 32'(1));
    chk("t3_drop", 32'(drop_cnt), 32'(4));
    out_log.delete();
    stall = 1'b0;
    drain(40 * 20);
    chk("t3_count", 32'(out_log.size()), 32'(17));
    ok = (out_log.size() == 17);
    for (int i = 0; i < 16 && i < out_log.size(); i++) if (out_log[i] != 8'h30 + 8'(i)) ok = 1'b0;
    chk("t3_data", 32'(ok), 32'(1));
    if (out_log.size() == 17) chk("t3_marker", 32'(out_log[16]), 32'(MK));
    chk("t3_drop_hold", 32'(drop_cnt), 32'(4));

    // 4: fill, drain, refill across the pointer wrap
    stall = 1'b1;
    for (int i = 0; i < 16; i++) put(8'h80 + 8'(i));
    chk("t4_full", 32'(full), 32'(1));
    stall = 1'b0;
    drain(40 * 20);
    chk("t4_empty", 32'(empty), 32'(1));
    out_log.delete();
    for (int i = 0; i < 3; i++) put(8'hC0 + 8'(i));
    drain(200);
    ok = (out_log.size() == 3);
    for (int i = 0; i < out_log.size(); i++) if (out_log[i] != 8'hC0 + 8'(i)) ok = 1'b0;
    chk("t4_refill", 32'(ok), 32'(1));

    // 5: async reset mid-frame
    uart_len = 50;
    stall    = 1'b1;
    for (int i = 0; i < 4; i++) put(8'h60 + 8'(i));
    stall = 1'b0;
    n = 0;
    while (!tx_dv && n < 20) begin
      @(negedge clk48);
      n++;
    end
    repeat (5) @(negedge clk48);
    chk("t5_level_pre", 32'(level), 32'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tx_dv", 32'(tx_dv), 32'(0));
    chk("t5_level", 32'(level), 32'(0));
    chk("t5_drop", 32'(drop_cnt), 32'(0));
    @(negedge clk48);
    #2 rst_n = 1'b1;
    @(negedge clk48);
    out_log.delete();
    put(8'h5A);
    drain(200);
    chk("t5_after", 32'(out_log.size() == 1 && out_log[0] == 8'h5A), 32'(1));

    // 6: drop counter saturation
    uart_len = 12;
    stall    = 1'b1;
    for (int i = 0; i < 16; i++) put(8'(i));
    #2;
    force dut.drop_cnt_q = 16'hFFFE;
    m_drop = 16'hFFFE;
    @(negedge clk48);
    #2;
    release dut.drop_cnt_q;
    @(negedge clk48);
    for (int i = 0; i < 3; i++) put(8'hEE);
    chk("t6_sat", 32'(drop_cnt), 32'(16'hFFFF));
    stall = 1'b0;
    drain(40 * 20);
    chk("t6_sat_hold", 32'(drop_cnt), 32'(16'hFFFF));

    // Random traffic across varying write rates and UART speeds
    for (int ph = 0; ph < 4; ph++) begin
      int rate;
      rate = (ph == 0) ? 10 : (ph == 1) ? 40 : (ph == 2) ? 80 : 25;
      for (int c = 0; c < 500; c++) begin
        wr_dv = ($urandom_range(0, 99) < rate);
        wr_d  = 8'($urandom);
        if (!u_busy && $urandom_range(0, 15) == 0) uart_len = $urandom_range(2, 40);
        if ($urandom_range(0, 63) == 0) stall = ~stall;
        @(negedge clk48);
      end
      wr_dv = 1'b0;
      stall = 1'b0;
      drain(40 * 45 + 100);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
